mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/load_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared load/store encodings, access FSM states and MAU defaults.
// Rev    : 1.0
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_SW = 2'd0,
        ST_SB = 2'd1,
        ST_SH = 2'd2
    } store_opt_e;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } load_opt_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mau_state_e;

    localparam int TIMEOUT_DEFAULT = 16;

    // Unknown option codes are treated as full-word accesses.
    function automatic logic is_misaligned(
        input logic       is_store,
        input logic [1:0] store_opt,
        input logic [2:0] load_opt,
        input logic [1:0] addr_lo
    );
        logic mis;
        mis = (addr_lo != 2'b00);
        if (is_store) begin
            case (store_opt)
                ST_SB:   mis = 1'b0;
                ST_SH:   mis = addr_lo[0];
                default: mis = (addr_lo != 2'b00);
            endcase
        end else begin
            case (load_opt)
                LD_LB, LD_LBU: mis = 1'b0;
                LD_LH, LD_LHU: mis = addr_lo[0];
                default:       mis = (addr_lo != 2'b00);
            endcase
        end
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module : load_align
// Brief  : Selects the addressed lane of a read word and sign/zero extends it.
// Rev    : 1.0
// ============================================================================
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  load_option_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata_i[7:0];
        case (offset_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        w_half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (load_option_i)
            LD_LB:   data_o = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  data_o = {24'h000000, w_byte};
            LD_LH:   data_o = {{16{w_half[15]}}, w_half};
            LD_LHU:  data_o = {16'h0000, w_half};
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit
// Brief  : MEM-stage load/store sequencer with alignment checks and ack timeout.
// Rev    : 1.0
// ============================================================================
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        EX_Valid,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic [31:0] EX_Addr,
    input  logic [31:0] EX_Wdata,
    input  logic [1:0]  EX_store_option,
    input  logic [2:0]  EX_load_option,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] ME_Dout,
    output logic        ME_Done,
    output logic        ME_Stall,
    output logic        ME_AddrErr,
    output logic        ME_BusErr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mau_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       addr_lo_q;
    logic [2:0]       load_opt_q;
    logic             dm_req_q;
    logic             dm_we_q;
    logic [31:0]      dm_addr_q;
    logic [31:0]      dm_wdata_q;
    logic [3:0]       dm_be_q;
    logic [31:0]      dout_q;
    logic             done_q;
    logic             addr_err_q;
    logic             bus_err_q;

    logic             w_access;
    logic             w_is_store;
    logic             w_misaligned;
    logic             w_accept;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_data;

    // A request carrying both read and write is handled as a store.
    assign w_access     = EX_Valid & (EX_MemRead | EX_MemWrite);
    assign w_is_store   = EX_MemWrite;
    assign w_misaligned = is_misaligned(w_is_store, EX_store_option,
                                        EX_load_option, EX_Addr[1:0]);
    assign w_accept     = (state_q == S_IDLE) & w_access & ~w_misaligned;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'h0000_0000;
        if (w_is_store) begin
            case (EX_store_option)
                ST_SB: begin
                    w_be    = 4'b0001 << EX_Addr[1:0];
                    w_wdata = {4{EX_Wdata[7:0]}};
                end
                ST_SH: begin
                    w_be    = EX_Addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{EX_Wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = EX_Wdata;
                end
            endcase
        end
    end

    load_align u_load_align (
        .rdata_i       (dm_rdata),
        .offset_i      (addr_lo_q),
        .load_option_i (load_opt_q),
        .data_o        (w_load_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_lo_q  <= 2'b00;
            load_opt_q <= 3'b000;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'h0;
            dm_wdata_q <= 32'h0;
            dm_be_q    <= 4'b0000;
            dout_q     <= 32'h0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_access && w_misaligned) begin
                        addr_err_q <= 1'b1;
                        done_q     <= 1'b1;
                    end else if (w_accept) begin
                        state_q    <= S_BUSY;
                        cnt_q      <= '0;
                        addr_lo_q  <= EX_Addr[1:0];
                        load_opt_q <= EX_load_option;
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= w_is_store;
                        dm_addr_q  <= {EX_Addr[31:2], 2'b00};
                        dm_wdata_q <= w_wdata;
                        dm_be_q    <= w_be;
                    end
                end
                S_BUSY: begin
                    if (dm_ack) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        dm_req_q <= 1'b0;
                        dm_we_q  <= 1'b0;
                        if (!dm_we_q) begin
                            dout_q <= w_load_data;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Ack never came: abandon the access, result unchanged.
                        state_q   <= S_IDLE;
                        done_q    <= 1'b1;
                        bus_err_q <= 1'b1;
                        dm_req_q  <= 1'b0;
                        dm_we_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dm_req     = dm_req_q;
    assign dm_we      = dm_we_q;
    assign dm_addr    = dm_addr_q;
    assign dm_wdata   = dm_wdata_q;
    assign dm_be      = dm_be_q;
    assign ME_Dout    = dout_q;
    assign ME_Done    = done_q;
    assign ME_AddrErr = addr_err_q;
    assign ME_BusErr  = bus_err_q;
    // Stall must be forced low while reset is held, even with a pending EX request.
    assign ME_Stall   = reset & ((state_q == S_BUSY) | w_accept);

endmodule
`default_nettype wire
